// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC, fetches from a sync ROM, and splits
// instructions into execute strobes and conditional jumps.
// Ports:
//   clock, reset_n    : clock and async active-low reset
//   run               : allow a new fetch (sampled only in FETCH)
//   instruction       : ROM read data, valid one cycle after pc
//   jump_target       : jump destination, used in BRANCH
//   cond_result       : registered condition result, valid in BRANCH
//   pc                : program counter / ROM address
//   fetch             : ROM read enable
//   cond_opcode       : condition op to the evaluator, held between jumps
//   exec_valid        : one-cycle strobe, exec_instruction is a datapath op
//   exec_instruction  : latched instruction register
//   jump_taken        : one-cycle strobe in BRANCH when the jump is taken
module program_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [7:0]            instruction,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  cond_result,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch,
  output logic [2:0]            cond_opcode,
  output logic                  exec_valid,
  output logic [7:0]            exec_instruction,
  output logic                  jump_taken
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_EVAL,
    S_BRANCH
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [2:0]            cop_nxt;
  logic [7:0]            ei_nxt;
  logic                  ev_nxt;
  logic                  is_jump;

  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign is_jump = (instruction[7:6] == 2'b11);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_FETCH;
      pc               <= RESET_PC;
      cond_opcode      <= 3'b000;
      exec_instruction <= 8'h00;
      exec_valid       <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      cond_opcode      <= cop_nxt;
      exec_instruction <= ei_nxt;
      exec_valid       <= ev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cop_nxt   = cond_opcode;
    ei_nxt    = exec_instruction;
    ev_nxt    = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ei_nxt = instruction;
        if (is_jump) begin
          cop_nxt   = instruction[2:0];
          state_nxt = S_EVAL;
        end else begin
          // exec_valid is a flop, so arm it as EXECUTE is entered
          ev_nxt    = 1'b1;
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_EVAL: begin
        state_nxt = S_BRANCH;
      end
      S_BRANCH: begin
        pc_nxt    = cond_result ? jump_target : pc_inc;
        state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // cond_result is already a flop output upstream; qualify it with state
  assign jump_taken = (state == S_BRANCH) && cond_result;
  assign fetch      = reset_n && run && (state == S_FETCH);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer.
// Sync ROM model, hand-computed expectations, immediate assertions.
module tb_program_sequencer;

  logic       clock;
  logic       reset_n;
  logic       run;
  logic [7:0] instruction;
  logic [7:0] jump_target;
  logic       cond_result;
  logic [7:0] pc;
  logic       fetch;
  logic [2:0] cond_opcode;
  logic       exec_valid;
  logic [7:0] exec_instruction;
  logic       jump_taken;

  logic [7:0] rom [256];

  int n_assert = 0;
  int n_fail   = 0;

  program_sequencer #(
    .ADDR_WIDTH(8),
    .RESET_PC(8'h00)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .run(run),
    .instruction(instruction),
    .jump_target(jump_target),
    .cond_result(cond_result),
    .pc(pc),
    .fetch(fetch),
    .cond_opcode(cond_opcode),
    .exec_valid(exec_valid),
    .exec_instruction(exec_instruction),
    .jump_taken(jump_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) instruction <= rom[pc];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
    chk("excl", {31'd0, exec_valid & jump_taken}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h05;
    rom[8'h01] = 8'hC1;
    rom[8'h02] = 8'hC0;
    rom[8'h03] = 8'hC7;
    rom[8'h40] = 8'hC3;
    rom[8'h12] = 8'hC5;
    rom[8'hFF] = 8'h2A;
    instruction = 8'h00;
    reset_n     = 1'b0;
    run         = 1'b0;
    cond_result = 1'b0;
    jump_target = 8'h00;

    step();
    step();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_fetch", 32'(fetch), 32'd0);
    chk("rst_ev", 32'(exec_valid), 32'd0);
    chk("rst_jt", 32'(jump_taken), 32'd0);
    chk("rst_cop", 32'(cond_opcode), 32'd0);
    chk("rst_ei", 32'(exec_instruction), 32'h00);

    reset_n = 1'b1;
    step();
    chk("idle_fetch", 32'(fetch), 32'd0);
    chk("idle_pc", 32'(pc), 32'h00);
    step();
    chk("idle_fetch2", 32'(fetch), 32'd0);

    // non-jump at 0
    run = 1'b1;
    #1;
    chk("c0_fetch", 32'(fetch), 32'd1);
    step();
    chk("c1_fetch", 32'(fetch), 32'd0);
    chk("c1_ev", 32'(exec_valid), 32'd0);
    step();
    chk("c2_ev", 32'(exec_valid), 32'd1);
    chk("c2_ei", 32'(exec_instruction), 32'h05);
    step();
    chk("c3_pc", 32'(pc), 32'h01);
    chk("c3_ev", 32'(exec_valid), 32'd0);
    chk("c3_fetch", 32'(fetch), 32'd1);

    // C1 taken to 0x40
    step();
    step();
    chk("j1_cop", 32'(cond_opcode), 32'd1);
    chk("j1_ei", 32'(exec_instruction), 32'hC1);
    chk("j1_ev", 32'(exec_valid), 32'd0);
    cond_result = 1'b1;
    jump_target = 8'h40;
    step();
    chk("j1_jt", 32'(jump_taken), 32'd1);
    chk("j1_pc_hold", 32'(pc), 32'h01);
    step();
    chk("j1_pc", 32'(pc), 32'h40);
    chk("j1_jt_off", 32'(jump_taken), 32'd0);
    cond_result = 1'b0;

    // C3 at 0x40 taken to 0x12
    step();
    step();
    chk("j2_cop", 32'(cond_opcode), 32'd3);
    cond_result = 1'b1;
    jump_target = 8'h12;
    step();
    chk("j2_jt", 32'(jump_taken), 32'd1);
    step();
    chk("j2_pc", 32'(pc), 32'h12);
    cond_result = 1'b0;

    // C5 at 0x12, reset in EVAL
    step();
    step();
    chk("j3_cop", 32'(cond_opcode), 32'd5);
    cond_result = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mr_pc", 32'(pc), 32'h00);
    chk("mr_cop", 32'(cond_opcode), 32'd0);
    chk("mr_jt", 32'(jump_taken), 32'd0);
    chk("mr_fetch", 32'(fetch), 32'd0);
    chk("mr_ei", 32'(exec_instruction), 32'h00);
    step();
    chk("mr_jt2", 32'(jump_taken), 32'd0);
    chk("mr_pc2", 32'(pc), 32'h00);
    reset_n = 1'b1;
    cond_result = 1'b0;
    #1;
    chk("mr_resume", 32'(fetch), 32'd1);

    // non-jump at 0 with run dropped during EXECUTE
    step();
    step();
    chk("r_ev", 32'(exec_valid), 32'd1);
    chk("r_ei", 32'(exec_instruction), 32'h05);
    run = 1'b0;
    step();
    chk("r_fetch", 32'(fetch), 32'd0);
    chk("r_pc", 32'(pc), 32'h01);
    step();
    chk("r_fetch2", 32'(fetch), 32'd0);
    chk("r_pc2", 32'(pc), 32'h01);
    chk("r_ev2", 32'(exec_valid), 32'd0);
    step();
    chk("r_pc3", 32'(pc), 32'h01);
    run = 1'b1;
    #1;
    chk("r_fetch3", 32'(fetch), 32'd1);

    // C1 not taken
    step();
    step();
    chk("nt_cop", 32'(cond_opcode), 32'd1);
    cond_result = 1'b0;
    jump_target = 8'h40;
    step();
    chk("nt_jt", 32'(jump_taken), 32'd0);
    step();
    chk("nt_pc", 32'(pc), 32'h02);

    // C0 never
    step();
    step();
    chk("nv_cop", 32'(cond_opcode), 32'd0);
    step();
    chk("nv_jt", 32'(jump_taken), 32'd0);
    step();
    chk("nv_pc", 32'(pc), 32'h03);

    // C7 taken to 0xFF
    step();
    step();
    chk("ge_cop", 32'(cond_opcode), 32'd7);
    cond_result = 1'b1;
    jump_target = 8'hFF;
    step();
    chk("ge_jt", 32'(jump_taken), 32'd1);
    step();
    chk("ge_pc", 32'(pc), 32'hFF);
    cond_result = 1'b0;

    // non-jump at 0xFF wraps
    step();
    step();
    chk("w_ev", 32'(exec_valid), 32'd1);
    chk("w_ei", 32'(exec_instruction), 32'h2A);
    step();
    chk("w_pc", 32'(pc), 32'h00);

    // 05 then C1 jumping to itself
    step();
    step();
    step();
    chk("s_pc0", 32'(pc), 32'h01);
    step();
    step();
    cond_result = 1'b1;
    jump_target = 8'h01;
    step();
    chk("s_jt", 32'(jump_taken), 32'd1);
    step();
    chk("s_pc", 32'(pc), 32'h01);
    cond_result = 1'b0;
    step();
    step();
    chk("s_ei", 32'(exec_instruction), 32'hC1);
    chk("s_cop", 32'(cond_opcode), 32'd1);
    step();
    chk("s_jt2", 32'(jump_taken), 32'd0);
    step();
    chk("s_pc2", 32'(pc), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
